branch_target_buffer: RTL and testbench

- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Sits directly upstream of the PC register.
- Each cycle it looks up the current fetch PC and drives the predict-taken flag and predicted target consumed by next-PC selection.
- The execute stage writes resolved branch outcomes back through an update port; mispredict redirection itself stays in the PC register.

---
 rtl/branch_target_buffer.sv | 109 ++++++++++
 tb/tb_branch_target_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_PERF_CNT_EN to add the perf_hits / perf_updates / perf_mispred counters.
module branch_target_buffer #(
    parameter int         ENTRIES  = 64,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] lookup_pc,
    output logic        pred_take,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_updates,
    output logic [31:0] perf_mispred
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_accept;
    logic             unused_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Lookup is purely combinational; a same-cycle update is not bypassed.
    assign l_idx       = lookup_pc[IDX_W+1:2];
    assign l_tag       = lookup_pc[31:IDX_W+2];
    assign hit         = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pred_take   = resetn && hit && cnt_q[l_idx][1] && (lookup_pc[1:0] == 2'b00);
    assign pred_target = pred_take ? {target_q[l_idx], 2'b00} : lookup_pc + 32'd4;

    assign u_idx    = upd_pc[IDX_W+1:2];
    assign u_tag    = upd_pc[31:IDX_W+2];
    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign u_accept = upd_valid && (upd_pc[1:0] == 2'b00);

    assign unused_bits = ^{upd_target[1:0], upd_mispredict};

    // NOTE: the table lives in flops rather than RAM, so every entry is reset
    // explicitly; sequential state is only ever written with non-blocking <=.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else if (u_accept) begin
            if (u_hit) begin
                if (!upd_is_branch) begin
                    valid_q[u_idx] <= 1'b0;
                end else if (upd_taken) begin
                    cnt_q[u_idx]    <= sat_inc(cnt_q[u_idx]);
                    target_q[u_idx] <= upd_target[31:2];
                end else begin
                    cnt_q[u_idx] <= sat_dec(cnt_q[u_idx]);
                end
            end else if (upd_is_branch && upd_taken) begin
                // Allocation evicts whatever occupied this index.
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target[31:2];
                cnt_q[u_idx]    <= 2'b10;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_hits    <= '0;
            perf_updates <= '0;
            perf_mispred <= '0;
        end else begin
            if (hit)                          perf_hits    <= perf_hits + 32'd1;
            if (u_accept)                     perf_updates <= perf_updates + 32'd1;
            if (upd_valid && upd_mispredict)  perf_mispred <= perf_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: stimulus pushes expected predictions,
// a negedge monitor pops and compares them.
module tb_branch_target_buffer;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
    } upd_t;

    typedef struct {
        logic        take;
        logic [31:0] target;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        pred_take;
    logic [31:0] pred_target;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic        upd_is_branch = 1'b0;
    logic        upd_taken = 1'b0;
    logic [31:0] upd_target = '0;
    logic        upd_mispredict = 1'b0;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_hits, perf_updates, perf_mispred;
`endif

    logic sample_en = 1'b0;
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] A  = 32'hbfc0_0010;
    localparam logic [31:0] B  = 32'hbfc0_0110;   // A + 64*4, same index
    localparam logic [31:0] T  = 32'hbfc0_0100;
    localparam logic [31:0] T2 = 32'hbfc0_0200;
    localparam logic [31:0] T3 = 32'hbfc0_0300;

    branch_target_buffer dut (
        .clk           (clk),
        .resetn        (resetn),
        .lookup_pc     (lookup_pc),
        .pred_take     (pred_take),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_is_branch (upd_is_branch),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispredict(upd_mispredict)
`ifdef BTB_PERF_CNT_EN
        ,
        .perf_hits     (perf_hits),
        .perf_updates  (perf_updates),
        .perf_mispred  (perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got take=%0b target=%08h, expected take=%0b target=%08h",
                     nm, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    function automatic upd_t mk(input logic [31:0] pc, input logic br, input logic tk,
                                input logic [31:0] tgt);
        upd_t u;
        u.v = 1'b1; u.pc = pc; u.br = br; u.tk = tk; u.tgt = tgt;
        return u;
    endfunction

    function automatic upd_t none();
        upd_t u;
        u.v = 1'b0; u.pc = '0; u.br = 1'b0; u.tk = 1'b0; u.tgt = '0;
        return u;
    endfunction

    // One clock cycle of stimulus; optionally queues the expected prediction.
    task automatic cyc(input logic rn, input upd_t u, input logic [31:0] lpc, input bit chk,
                       input logic et, input logic [31:0] etg, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        resetn         = rn;
        upd_valid      = u.v;
        upd_pc         = u.pc;
        upd_is_branch  = u.br;
        upd_taken      = u.tk;
        upd_target     = u.tgt;
        upd_mispredict = u.v;
        lookup_pc      = lpc;
        sample_en      = chk;
        if (chk) begin
            e.take = et; e.target = etg; e.name = nm;
            sb.push_back(e);
        end
    endtask

    // Apply an update to A, then check the lookup of A on the following cycle.
    task automatic walk(input logic tk, input logic [31:0] tgt, input logic et,
                        input logic [31:0] etg, input string nm);
        cyc(1'b1, mk(A, 1'b1, tk, tgt), A, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), A, 1'b1, et, etg, nm);
    endtask

    always @(negedge clk) begin
        if (sample_en) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got output with no expectation queued");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, {pred_take, pred_target}, {e.take, e.target});
            end
        end
    end

    initial begin
        // Reset: predictions are gated off while resetn is low.
        cyc(1'b0, none(), 32'hbfc0_0000, 1'b1, 1'b0, 32'hbfc0_0004, "reset_lookup0");
        cyc(1'b0, none(), 32'hbfc0_0000, 1'b1, 1'b0, 32'hbfc0_0004, "reset_lookup1");
        for (int i = 0; i < 64; i++)
            cyc(1'b1, none(), 32'hbfc0_0000 + 32'(4 * i), 1'b1, 1'b0,
                32'hbfc0_0004 + 32'(4 * i), $sformatf("empty_idx%0d", i));

        // Allocation; the same-cycle lookup still sees the empty entry.
        cyc(1'b1, mk(A, 1'b1, 1'b1, T), A, 1'b1, 1'b0, A + 4, "same_cycle_no_bypass");
        cyc(1'b1, none(), A, 1'b1, 1'b1, T, "alloc_hit");

        // Counter walk starting from cnt=10.
        walk(1'b0, 32'h0, 1'b0, A + 4, "nt_cnt01");
        walk(1'b0, 32'h0, 1'b0, A + 4, "nt_cnt00");
        walk(1'b1, T,     1'b0, A + 4, "tk_cnt01");
        walk(1'b1, T,     1'b1, T,     "tk_cnt10");
        walk(1'b1, T2,    1'b1, T2,    "tk_cnt11_new_target");
        walk(1'b1, T2,    1'b1, T2,    "tk_sat11");
        walk(1'b0, 32'h0, 1'b1, T2,    "nt_cnt10_target_kept");
        walk(1'b0, 32'h0, 1'b0, A + 4, "nt_cnt01_b");
        walk(1'b0, 32'h0, 1'b0, A + 4, "nt_cnt00_b");
        walk(1'b0, 32'h0, 1'b0, A + 4, "nt_sat00");
        walk(1'b1, T,     1'b0, A + 4, "tk_from_sat00");
        walk(1'b1, T,     1'b1, T,     "tk_cnt10_after_sat");

        // Alias replacement, then invalidation by a non-branch.
        cyc(1'b1, mk(B, 1'b1, 1'b1, T3), B, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), A, 1'b1, 1'b0, A + 4, "alias_old_miss");
        cyc(1'b1, none(), B, 1'b1, 1'b1, T3, "alias_new_hit");
        cyc(1'b1, mk(B, 1'b0, 1'b1, T3), B, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), B, 1'b1, 1'b0, B + 4, "nonbranch_invalidate");

        // No allocation on not-taken, non-branch, or misaligned updates.
        cyc(1'b1, mk(32'hbfc0_0020, 1'b1, 1'b0, T), 32'hbfc0_0020, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), 32'hbfc0_0020, 1'b1, 1'b0, 32'hbfc0_0024, "nt_no_alloc");
        cyc(1'b1, mk(32'hbfc0_0024, 1'b0, 1'b1, T), 32'hbfc0_0024, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), 32'hbfc0_0024, 1'b1, 1'b0, 32'hbfc0_0028, "nonbranch_no_alloc");
        cyc(1'b1, mk(32'hbfc0_0022, 1'b1, 1'b1, T), 32'hbfc0_0020, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), 32'hbfc0_0020, 1'b1, 1'b0, 32'hbfc0_0024, "misaligned_upd_ignored");

        // Misaligned lookup on an allocated index.
        cyc(1'b1, mk(A, 1'b1, 1'b1, T), A, 1'b0, 1'b0, '0, "");
        cyc(1'b1, none(), A, 1'b1, 1'b1, T, "realloc_hit");
        cyc(1'b1, none(), 32'hbfc0_0012, 1'b1, 1'b0, 32'hbfc0_0016, "misaligned_lookup");

        // Reset mid-run with a concurrent update that must be discarded.
        cyc(1'b0, mk(32'hbfc0_0040, 1'b1, 1'b1, T), A, 1'b1, 1'b0, A + 4, "reset_gates_pred");
        cyc(1'b1, none(), A, 1'b1, 1'b0, A + 4, "reset_cleared");
`ifdef BTB_PERF_CNT_EN
        @(negedge clk);
        check("perf_hits_reset",    {1'b0, perf_hits},    33'd0);
        check("perf_updates_reset", {1'b0, perf_updates}, 33'd0);
        check("perf_mispred_reset", {1'b0, perf_mispred}, 33'd0);
`endif
        cyc(1'b1, none(), 32'hbfc0_0040, 1'b1, 1'b0, 32'hbfc0_0044, "reset_discards_upd");

        @(posedge clk);
        #1;
        sample_en = 1'b0;
        @(posedge clk);
        check("scoreboard_drained", 33'(sb.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
